credit_return_fifo: RTL and testbench
=====================================

// Module: credit_return_fifo
// PURPOSE
//   Elastic output queue placed directly downstream of a fixed-latency, non-stallable
//   delay line (the `buffering` stage, instantiated with SIZE=WIDTH+1, DELAY=LATENCY,
//   data plus a valid bit).
//   - Grants issue credits upstream so every word entering the delay line has a
//     guaranteed FIFO slot.
//   - Presents the words downstream on a valid/ready interface, so a downstream stall
//     never loses data.
// PARAMETERS
//   WIDTH    8  data width of pipe_data / o_data
//   DEPTH    8  FIFO entries; power of two, DEPTH >= 2
//   LATENCY  4  delay-line depth in cycles; used only for the post-reset flush; >= 0
// PORTS
//   clk          in   1         rising-edge clock
//   rst_n        in   1         synchronous active-low reset
//   issue_valid  in   1         upstream presents a word to the delay line this cycle
//   issue_ready  out  1         credit available; issue accepted when valid && ready
//   pipe_valid   in   1         valid bit emerging from the delay line
//   pipe_data    in   WIDTH     data emerging from the delay line
//   o_valid      out  1         FIFO non-empty
//   o_data       out  WIDTH     head-of-FIFO word
//   o_ready      in   1         downstream accepts; pop when o_valid && o_ready
//   occupancy    out  CW        words held in the FIFO; CW = $clog2(DEPTH+1)
//   err          out  1         sticky protocol error (feature-gated)
// BEHAVIOUR
//   - Reset values (rst_n low at a clk edge):
//     - occupancy = 0, inflight = 0, rd_ptr = wr_ptr = 0.
//     - o_valid = 0, issue_ready = 0, err = 0.
//     - The flush counter is loaded with LATENCY.
//     - o_data is don't-care while o_valid = 0.
//   - Flush: the delay line has no reset.
//     - While the flush counter is nonzero it decrements each cycle.
//     - During flush, pipe_valid is ignored and issue_ready = 0.
//     - Reset asserted mid-operation discards FIFO contents and in-flight words, then
//       flushes again.
//     - With LATENCY = 0, normal operation starts on the first cycle after reset.
//   - Credit rule:
//     - issue_ready = !flushing && (occupancy + inflight < DEPTH), combinational from
//       registered state.
//     - issue_valid has no effect when issue_ready = 0.
//   - inflight update (registered, CW bits):
//     - +1 on an accepted issue; -1 on an accepted pipe_valid; unchanged when both
//       occur in the same cycle.
//   - Write: an accepted pipe_valid writes pipe_data at wr_ptr; wr_ptr increments,
//     wrapping modulo DEPTH.
//   - Read:
//     - First-word fall-through: o_valid = (occupancy != 0) and o_data = mem[rd_ptr],
//       both registered-state driven.
//     - A pop increments rd_ptr, wrapping modulo DEPTH.
//   - Simultaneous write and pop: occupancy unchanged, both pointers advance. This is
//     legal when the FIFO is full and when it holds exactly one word.
//   - Latency:
//     - pipe_valid at cycle t gives o_valid = 1 at t+1 when the FIFO was empty.
//     - Issue-to-output latency is LATENCY+1 cycles.
//   - The credit rule guarantees no write while full and at most DEPTH outstanding
//     words.
//   - Throughput: one issue, one write and one pop per cycle when DEPTH >= LATENCY+2
//     and o_ready is held at 1.
// CONFIGURATION
//   CRF_ERR_CHECK_EN
//     - Defined: err sets, and stays set until reset, when an accepted pipe_valid
//       arrives while either:
//       - inflight == 0 (spurious arrival); or
//       - occupancy == DEPTH with no simultaneous pop (overflow).
//     - Defined: the offending word is dropped and inflight is not decremented.
//     - Not defined: err is tied 0, the check logic is absent and every arrival is
//       written unconditionally.
// TESTING
//   1. Reset, LATENCY=4: issue_ready=0 for 4 cycles after rst_n rises, then 1;
//      pipe_valid=1 during the flush leaves occupancy=0.
//   2. Issue 0xA5 at t0 with o_ready=1: pipe_valid/0xA5 at t0+4, o_valid=1 and
//      o_data=0xA5 at t0+5, occupancy returns to 0 at t0+6.
//   3. o_ready=0, issue continuously: exactly 8 issues accepted, issue_ready=0 once
//      occupancy+inflight=8; after all arrivals occupancy=8. Raise o_ready: words pop
//      in issue order and credits reopen.
//   4. FIFO full, and on the same cycle a pipe arrival coincides with a pop:
//      occupancy stays 8, output order is preserved across pointer wrap from 7 to 0.
//   5. CRF_ERR_CHECK_EN defined: force pipe_valid=1 with inflight=0 -> err=1 next
//      cycle, occupancy unchanged, err held until rst_n=0.
//   6. Assert rst_n=0 for 1 cycle with 3 words in flight and 2 queued: o_valid=0,
//      occupancy=0, and the 3 stale words emerging during the flush are not written.

Source files
------------

// File: rtl/credit_return_fifo_if.sv
// ---------------------------------------------------------------------------
// credit_return_fifo_if
//   Handshake bundle around the credit-return FIFO.
//     issue_valid / issue_ready : upstream issue into the delay line (credit)
//     pipe_valid  / pipe_data   : words emerging from the fixed-latency delay line
//     o_valid / o_data / o_ready: downstream valid/ready output
//   master : the environment side (upstream source, delay line, downstream sink)
//   slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface credit_return_fifo_if #(
    parameter int WIDTH = 8
) ();
    logic             issue_valid;
    logic             issue_ready;
    logic             pipe_valid;
    logic [WIDTH-1:0] pipe_data;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_ready;

    modport master (
        output issue_valid,
        input  issue_ready,
        output pipe_valid,
        output pipe_data,
        input  o_valid,
        input  o_data,
        output o_ready
    );

    modport slave (
        input  issue_valid,
        output issue_ready,
        input  pipe_valid,
        input  pipe_data,
        output o_valid,
        output o_data,
        input  o_ready
    );
endinterface

// File: rtl/credit_return_fifo.sv
// ---------------------------------------------------------------------------
// credit_return_fifo
//   Elastic output queue sitting behind a fixed-latency, non-stallable delay
//   line. Credits are granted upstream only while occupancy + inflight leaves
//   room, so every word entering the delay line is guaranteed a slot here.
//   After reset the delay line may still hold stale words (it has no reset),
//   so arrivals are ignored and no credits are granted for LATENCY cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        credit_return_fifo_if.slave (issue, pipe and output handshakes)
//   occupancy  number of words held, $clog2(DEPTH+1) bits
//   err        sticky protocol error (only with CRF_ERR_CHECK_EN, else 0)
//
// Configuration macro
//   CRF_ERR_CHECK_EN : when defined, spurious arrivals (nothing in flight) and
//   overflowing arrivals (full, no simultaneous pop) are dropped and set err.
//   When undefined every arrival is written and err is tied low.
// ---------------------------------------------------------------------------
module credit_return_fifo #(
    parameter int  WIDTH   = 8,
    parameter int  DEPTH   = 8,
    parameter int  LATENCY = 4,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    credit_return_fifo_if.slave     bus,
    output logic [CW-1:0]           occupancy,
    output logic                    err
);

    localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              FW         = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [FW-1:0]   FLUSH_INIT = FW'(LATENCY);
    localparam logic [CW:0]     DEPTH_W    = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    occ_r;
    logic [CW-1:0]    inflight_r;
    logic [FW-1:0]    flush_cnt_r;

    logic             flushing_s;
    logic [CW:0]      committed_s;
    logic             credit_s;
    logic             issue_acc_s;
    logic             arrive_s;
    logic             pop_s;
    logic             drop_s;
    logic             write_s;

    // Credit, arrival, pop and drop decisions from registered state
    always_comb begin
        flushing_s  = (flush_cnt_r != '0);
        // One extra bit so occupancy + inflight never wraps
        committed_s = {1'b0, occ_r} + {1'b0, inflight_r};
        credit_s    = !flushing_s && (committed_s < DEPTH_W);
        issue_acc_s = bus.issue_valid && credit_s;
        // Stale delay-line contents are ignored while flushing
        arrive_s    = bus.pipe_valid && !flushing_s;
        pop_s       = (occ_r != '0) && bus.o_ready;
`ifdef CRF_ERR_CHECK_EN
        drop_s      = arrive_s &&
                      ((inflight_r == '0) ||
                       ((occ_r == CW'(DEPTH)) && !pop_s));
`else
        drop_s      = 1'b0;
`endif
        write_s     = arrive_s && !drop_s;
    end

    // Control state: flush counter, pointers, occupancy and in-flight count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt_r <= FLUSH_INIT;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            occ_r       <= '0;
            inflight_r  <= '0;
        end else begin
            if (flushing_s) begin
                flush_cnt_r <= flush_cnt_r - FW'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end

            // DEPTH is a power of two, so pointer wrap is the natural overflow
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            case ({write_s, pop_s})
                2'b10:   occ_r <= occ_r + CW'(1);
                2'b01:   occ_r <= occ_r - CW'(1);
                default: occ_r <= occ_r;
            endcase

            // A dropped arrival does not return its credit
            case ({issue_acc_s, write_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Storage array; contents need no reset because o_valid gates o_data
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wr_ptr_r] <= bus.pipe_data;
        end
    end

`ifdef CRF_ERR_CHECK_EN
    logic err_r;

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (drop_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign bus.issue_ready = credit_s;
    assign bus.o_valid     = (occ_r != '0);
    assign bus.o_data      = mem_r[rd_ptr_r];
    assign occupancy       = occ_r;

endmodule

// File: tb/tb_credit_return_fifo.sv
// ---------------------------------------------------------------------------
// tb_credit_return_fifo
//   Bench for credit_return_fifo (WIDTH=8, DEPTH=8, LATENCY=4). A behavioural
//   delay line feeds pipe_valid/pipe_data from accepted issues; a reference
//   queue receives each word the FIFO should store and is popped when the
//   FIFO delivers a word downstream.
// ---------------------------------------------------------------------------
module tb_credit_return_fifo;

    localparam int W   = 8;
    localparam int D   = 8;
    localparam int LAT = 4;
    localparam int CW  = $clog2(D + 1);

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] occupancy;
    logic          err;
    logic          force_v;
    logic [W-1:0]  iss_data;

    credit_return_fifo_if #(.WIDTH(W)) itf ();

    credit_return_fifo #(.WIDTH(W), .DEPTH(D), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (itf),
        .occupancy (occupancy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural delay line: no reset, as in the real pipeline
    logic [LAT-1:0] dl_v = '0;
    logic [W-1:0]   dl_d [LAT] = '{default: 8'h00};

    always @(posedge clk) begin
        dl_v    <= {dl_v[LAT-2:0], itf.issue_valid && itf.issue_ready};
        dl_d[0] <= iss_data;
        for (int k = 1; k < LAT; k++) dl_d[k] <= dl_d[k-1];
    end

    assign itf.pipe_valid = dl_v[LAT-1] | force_v;
    assign itf.pipe_data  = dl_d[LAT-1];

    // Reference state
    int           total = 0;
    int           bad   = 0;
    bit           m_live = 1'b0;
    int           m_inf  = 0;
    int           m_flush = 0;
    bit           m_err  = 1'b0;
    int           m_wp_cnt = 0;
    logic [W-1:0] m_q [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Check outputs against the model for the current cycle, advance the model
    // across the next rising edge, and move to the following negative edge.
    task automatic step();
        bit exp_rdy, acc_iss, acc_pipe, pop, drop, wr;
        #1;
        if (!rst_n) begin
            m_live  = 1'b1;
            m_inf   = 0;
            m_flush = LAT;
            m_err   = 1'b0;
            m_q.delete();
        end else if (m_live) begin
            exp_rdy = (m_flush == 0) && ((m_q.size() + m_inf) < D);
            check_eq("issue_ready", 32'(itf.issue_ready), 32'(exp_rdy));
            check_eq("o_valid", 32'(itf.o_valid), 32'(m_q.size() != 0));
            check_eq("occupancy", 32'(occupancy), 32'(m_q.size()));
            check_eq("err", 32'(err), 32'(m_err));
            pop      = (m_q.size() != 0) && itf.o_ready;
            acc_iss  = itf.issue_valid && exp_rdy;
            acc_pipe = itf.pipe_valid && (m_flush == 0);
            drop     = 1'b0;
`ifdef CRF_ERR_CHECK_EN
            drop = acc_pipe && ((m_inf == 0) || ((m_q.size() == D) && !pop));
            if (drop) m_err = 1'b1;
`endif
            wr = acc_pipe && !drop;
            if (pop) begin
                check_eq("o_data", 32'(itf.o_data), 32'(m_q[0]));
                void'(m_q.pop_front());
            end
            if (wr) m_q.push_back(itf.pipe_data);
            if (wr && pop) m_wp_cnt++;
            m_inf = m_inf + (acc_iss ? 1 : 0) - (wr ? 1 : 0);
            if (m_flush != 0) m_flush--;
        end
        @(negedge clk);
    endtask

    int  n;
    int  acc_n;
    bit  reopened;

    initial begin
        rst_n           = 1'b0;
        force_v         = 1'b0;
        iss_data        = 8'h00;
        itf.issue_valid = 1'b0;
        itf.o_ready     = 1'b0;
        @(negedge clk);
        step();
        step();
        check_eq("rst_o_valid", 32'(itf.o_valid), 32'd0);
        check_eq("rst_occ", 32'(occupancy), 32'd0);
        check_eq("rst_issue_ready", 32'(itf.issue_ready), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        // 1: flush length, arrivals ignored during flush
        rst_n   = 1'b1;
        force_v = 1'b1;
        n       = 0;
        while (itf.issue_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        force_v = 1'b0;
        check_eq("flush_len", 32'(n), 32'd4);
        check_eq("flush_occ", 32'(occupancy), 32'd0);

        // 2: single word latency
        itf.o_ready     = 1'b1;
        iss_data        = 8'hA5;
        itf.issue_valid = 1'b1;
        step();
        itf.issue_valid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            check_eq("t2_pipe_early", 32'(itf.pipe_valid), 32'd0);
            step();
        end
        check_eq("t2_pipe_v", 32'(itf.pipe_valid), 32'd1);
        check_eq("t2_pipe_d", 32'(itf.pipe_data), 32'hA5);
        check_eq("t2_ov_early", 32'(itf.o_valid), 32'd0);
        step();
        check_eq("t2_ov", 32'(itf.o_valid), 32'd1);
        check_eq("t2_od", 32'(itf.o_data), 32'hA5);
        step();
        check_eq("t2_occ0", 32'(occupancy), 32'd0);

        // 3: credit exhaustion with stalled output, then drain in order
        itf.o_ready     = 1'b0;
        itf.issue_valid = 1'b1;
        acc_n           = 0;
        for (int i = 0; i < 16; i++) begin
            iss_data = 8'h10 + 8'(i);
            if (itf.issue_ready === 1'b1) acc_n++;
            step();
        end
        itf.issue_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_eq("t3_accepted", 32'(acc_n), 32'd8);
        check_eq("t3_full", 32'(occupancy), 32'd8);
        check_eq("t3_no_credit", 32'(itf.issue_ready), 32'd0);
        itf.o_ready     = 1'b1;
        itf.issue_valid = 1'b1;
        reopened        = 1'b0;
        for (int i = 0; i < 30; i++) begin
            iss_data = 8'h40 + 8'(i);
            step();
            if (itf.issue_ready === 1'b1) reopened = 1'b1;
        end
        check_eq("t3_reopen", 32'(reopened), 32'd1);

        // 4: refill to full, then bursty output so arrivals coincide with pops
        itf.o_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            iss_data = 8'h80 + 8'(i);
            step();
        end
        check_eq("t4_full", 32'(occupancy), 32'd8);
        m_wp_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            iss_data    = 8'h90 + 8'(i);
            itf.o_ready = (i % 3) != 0;
            step();
        end
        check_eq("t4_wr_pop_seen", 32'(m_wp_cnt > 0), 32'd1);
        itf.issue_valid = 1'b0;
        itf.o_ready     = 1'b1;
        for (int i = 0; i < 16; i++) step();
        check_eq("t4_drained", 32'(occupancy), 32'd0);

        // 5: spurious arrival
`ifdef CRF_ERR_CHECK_EN
        force_v = 1'b1;
        step();
        force_v = 1'b0;
        check_eq("t5_err", 32'(err), 32'd1);
        check_eq("t5_occ", 32'(occupancy), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check_eq("t5_hold", 32'(err), 32'd1);
`else
        check_eq("t5_err_off", 32'(err), 32'd0);
`endif
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("t5_err_clr", 32'(err), 32'd0);
        n = 0;
        while (itf.issue_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_eq("t5_reflush", 32'(n), 32'd4);

        // 6: reset with 2 queued and 3 in flight
        itf.o_ready     = 1'b0;
        itf.issue_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            iss_data = 8'hC0 + 8'(i);
            step();
        end
        itf.issue_valid = 1'b0;
        step();
        check_eq("t6_pre_occ", 32'(occupancy), 32'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("t6_o_valid", 32'(itf.o_valid), 32'd0);
        check_eq("t6_occ", 32'(occupancy), 32'd0);
        itf.o_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_eq("t6_stale_occ", 32'(occupancy), 32'd0);
        check_eq("t6_stale_ov", 32'(itf.o_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
